// File: rtl/vx_cache_fill_buffer_pkg.sv
// Shared definitions for the cache fill buffer.
//   guard_state_e : one-cycle issue guard following each accepted fill
//   log2up        : address/counter width helper, never narrower than 1 bit
package vx_cache_fill_buffer_pkg;

   typedef enum logic {
      GUARD_IDLE = 1'b0,
      GUARD_HOLD = 1'b1
   } guard_state_e;

   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_cache_fill_buffer_dp_ram.sv
// Fill-entry storage: one synchronous write port and one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's pointers/count.
//   clk_i    : clock
//   wr_en_i  : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module vx_cache_fill_buffer_dp_ram
   import vx_cache_fill_buffer_pkg::*;
#(
   parameter int DATAW = 8,
   parameter int SIZE  = 2
) (
   input  logic                     clk_i,
   input  logic                     wr_en_i,
   input  logic [log2up(SIZE)-1:0]  waddr_i,
   input  logic [DATAW-1:0]         wdata_i,
   input  logic [log2up(SIZE)-1:0]  raddr_i,
   output logic [DATAW-1:0]         rdata_o
);

   logic [DATAW-1:0] mem_q [SIZE];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vx_cache_fill_buffer.sv
// Per-bank fill buffer between the memory response bus and bank stage 0.
// Buffers memory fill responses in arrival order and issues them one at a
// time while the MSHR replay chain is idle. Counts blocked-fill cycles.
//   clk_i / reset_i   : clock, asynchronous active-high reset
//   mem_rsp_*_i / _o  : memory response push side (valid/data/tag, ready)
//   replay_busy_i     : MSHR replay chain in progress, blocks issue
//   fill_*_o / _i     : fill request to stage 0 (valid/id/data, ready)
//   count_o           : current occupancy
//   perf_stalls_o     : saturating count of blocked-fill cycles
module vx_cache_fill_buffer
   import vx_cache_fill_buffer_pkg::*;
#(
   parameter int LINE_SIZE       = 16,
   parameter int MSHR_SIZE       = 4,
   parameter int FILL_DEPTH      = 2,
   parameter int MSHR_ADDR_WIDTH = log2up(MSHR_SIZE),
   parameter int PERF_WIDTH      = 32
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              mem_rsp_valid_i,
   input  logic [LINE_SIZE*8-1:0]            mem_rsp_data_i,
   input  logic [MSHR_ADDR_WIDTH-1:0]        mem_rsp_tag_i,
   output logic                              mem_rsp_ready_o,
   input  logic                              replay_busy_i,
   output logic                              fill_valid_o,
   output logic [MSHR_ADDR_WIDTH-1:0]        fill_id_o,
   output logic [LINE_SIZE*8-1:0]            fill_data_o,
   input  logic                              fill_ready_i,
   output logic [log2up(FILL_DEPTH+1)-1:0]   count_o,
   output logic [PERF_WIDTH-1:0]             perf_stalls_o
);

   localparam int CS_LINE_WIDTH = LINE_SIZE * 8;
   localparam int ADDR_W        = log2up(FILL_DEPTH);
   localparam int CNT_W         = log2up(FILL_DEPTH + 1);

   typedef struct packed {
      logic [MSHR_ADDR_WIDTH-1:0] tag;
      logic [CS_LINE_WIDTH-1:0]   data;
   } fill_entry_t;

   localparam int ENTRY_W = $bits(fill_entry_t);

   function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
      return (&v) ? v : v + PERF_WIDTH'(1);
   endfunction

   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PERF_WIDTH-1:0] perf_q, perf_d;
   guard_state_e          guard_q, guard_d;

   logic                  empty, full, push, pop, stall, fill_valid;
   fill_entry_t           wr_entry, rd_entry;
   logic [ENTRY_W-1:0]    rd_raw;

   // Ready depends only on registered occupancy, so a pop cannot free a slot
   // for a push in the same cycle.
   assign empty           = (count_q == '0);
   assign full            = (count_q == CNT_W'(FILL_DEPTH));
   assign mem_rsp_ready_o = ~full;
   assign push            = mem_rsp_valid_i & ~full;

   assign wr_entry.tag  = mem_rsp_tag_i;
   assign wr_entry.data = mem_rsp_data_i;

   vx_cache_fill_buffer_dp_ram #(
      .DATAW (ENTRY_W),
      .SIZE  (FILL_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en_i (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_raw)
   );

   assign rd_entry = fill_entry_t'(rd_raw);

   // Guard FSM: after a fill is accepted, block issue for one cycle so the
   // MSHR can register its dequeue valid before another fill could overlap.
   always_comb begin
      guard_d    = guard_q;
      fill_valid = ~empty & ~replay_busy_i & (guard_q == GUARD_IDLE);
      pop        = fill_valid & fill_ready_i;
      case (guard_q)
         GUARD_IDLE: if (pop) guard_d = GUARD_HOLD;
         GUARD_HOLD: guard_d = GUARD_IDLE;
         default:    guard_d = GUARD_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      stall    = ~empty & (replay_busy_i | (guard_q == GUARD_HOLD));
      perf_d   = stall ? sat_inc(perf_q) : perf_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         perf_q   <= '0;
         guard_q  <= GUARD_IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         perf_q   <= perf_d;
         guard_q  <= guard_d;
      end
   end

   assign fill_valid_o  = fill_valid;
   assign fill_id_o     = rd_entry.tag;
   assign fill_data_o   = rd_entry.data;
   assign count_o       = count_q;
   assign perf_stalls_o = perf_q;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(mem_rsp_valid_i && mem_rsp_ready_o && full));
         assert (!(pop && empty));
      end
   end

   // Tags are only range-limited when the MSHR count leaves unused encodings.
   if ((MSHR_SIZE & (MSHR_SIZE - 1)) != 0) begin : g_tag_chk
      always_ff @(posedge clk_i) begin
         if (!reset_i && push) begin
            assert (int'(mem_rsp_tag_i) < MSHR_SIZE);
         end
      end
   end

endmodule
